// File: rtl/alu_stack_seq_if.sv
// Command channel from instruction decode into the stack/ALU execute sequencer.
// The master side offers the commands and the slave side accepts them.
interface alu_stack_seq_if #(
  parameter int unsigned W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_lit;
  logic [4:0]   cmd_op;
  logic [W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_lit,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_lit,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/alu_stack_seq.sv
// Execute sequencer for the stack CPU: owns the data stack and steps each command through
// read, ALU and writeback phases according to the opcode's fixed stack effect.
module alu_stack_seq #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_stack_seq_if.slave       cmd,
  output logic [4:0]           alu_op,
  output logic [W-1:0]         alu_in0,
  output logic [W-1:0]         alu_in1,
  input  logic [W-1:0]         alu_out0,
  input  logic [W-1:0]         alu_out1,
  output logic [W-1:0]         tos,
  output logic [DW-1:0]        depth,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned DW1 = DW + 1;

  typedef enum logic [1:0] {StIdle, StRd, StEx, StWb} state_e;

  state_e         state_q;
  logic [W-1:0]   stack_q [DEPTH];
  logic [DW-1:0]  depth_q;
  logic [W-1:0]   tos_q;
  logic           err_q;
  logic           done_q;
  logic [4:0]     op_q;
  logic [W-1:0]   r0_q;
  logic [W-1:0]   r1_q;
  logic [1:0]     npop_q;
  logic [1:0]     npush_q;
  logic [4:0]     alu_op_q;
  logic [W-1:0]   alu_in0_q;
  logic [W-1:0]   alu_in1_q;

  logic [1:0]     eff_pop;
  logic [1:0]     eff_push;
  logic [DW1-1:0] depth_after;
  logic           underflow;
  logic           overflow;
  logic           full;
  logic [DW-1:0]  wb_base;

  // Stack effect of the latched opcode; undefined opcodes retire as no-ops.
  always_comb begin
    eff_pop  = 2'd0;
    eff_push = 2'd0;
    case (op_q)
      5'd0, 5'd1: begin
        eff_pop  = 2'd0;
        eff_push = 2'd1;
      end
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd13, 5'd14, 5'd15: begin
        eff_pop  = 2'd2;
        eff_push = 2'd1;
      end
      5'd8, 5'd12, 5'd17, 5'd18: begin
        eff_pop  = 2'd1;
        eff_push = 2'd1;
      end
      5'd10, 5'd16: begin
        eff_pop  = 2'd2;
        eff_push = 2'd2;
      end
      5'd11: begin
        eff_pop  = 2'd1;
        eff_push = 2'd2;
      end
      default: begin
        eff_pop  = 2'd0;
        eff_push = 2'd0;
      end
    endcase
  end

  always_comb begin
    underflow   = depth_q < DW'(eff_pop);
    depth_after = {1'b0, depth_q} - DW1'(eff_pop) + DW1'(eff_push);
    overflow    = !underflow && (depth_after > DW1'(DEPTH));
    full        = depth_q == DW'(DEPTH);
    wb_base     = depth_q - DW'(npop_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      depth_q   <= '0;
      tos_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      alu_op_q  <= '0;
      alu_in0_q <= '0;
      alu_in1_q <= '0;
    end else begin
      done_q <= 1'b0;
      // A later set in this same cycle overrides the clear.
      if (err_clr) err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd.cmd_valid) begin
            op_q   <= cmd.cmd_op;
            r0_q   <= cmd.cmd_data;
            npop_q <= 2'd0;
            if (cmd.cmd_lit) begin
              state_q <= StWb;
              if (full) begin
                npush_q <= 2'd0;
                err_q   <= 1'b1;
              end else begin
                npush_q <= 2'd1;
              end
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          if (underflow || overflow) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            npop_q  <= eff_pop;
            npush_q <= eff_push;
            if (eff_push == 2'd0) begin
              state_q <= StWb;
            end else begin
              state_q   <= StEx;
              alu_op_q  <= op_q;
              alu_in0_q <= (depth_q >= DW'(1)) ? stack_q[AW'(depth_q - DW'(1))] : '0;
              alu_in1_q <= (depth_q >= DW'(2)) ? stack_q[AW'(depth_q - DW'(2))] : '0;
            end
          end
        end
        StEx: begin
          r0_q    <= alu_out0;
          r1_q    <= alu_out1;
          state_q <= StWb;
        end
        StWb: begin
          // Two-result ops push r1 below r0 so r0 lands on top.
          if (npush_q == 2'd2) begin
            stack_q[AW'(wb_base)]          <= r1_q;
            stack_q[AW'(wb_base + DW'(1))] <= r0_q;
          end else if (npush_q == 2'd1) begin
            stack_q[AW'(wb_base)] <= r0_q;
          end
          if (npush_q != 2'd0) tos_q <= r0_q;
          depth_q <= wb_base + DW'(npush_q);
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd.cmd_ready = (state_q == StIdle);
  assign alu_op        = alu_op_q;
  assign alu_in0       = alu_in0_q;
  assign alu_in1       = alu_in1_q;
  assign tos           = tos_q;
  assign depth         = depth_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_alu_stack_seq.sv
// Directed bench for alu_stack_seq: a small behavioural ALU closes the loop, and each command's
// latency, EX-phase ALU drive and resulting stack state are checked against hand-computed values.
module tb_alu_stack_seq;

  logic        clk;
  logic        rst;
  logic [4:0]  alu_op;
  logic [15:0] alu_in0;
  logic [15:0] alu_in1;
  logic [15:0] alu_out0;
  logic [15:0] alu_out1;
  logic [15:0] tos;
  logic [3:0]  depth;
  logic        done;
  logic        err;
  logic        err_clr;

  logic [4:0]  ex_op;
  logic [15:0] ex_in0;
  logic [15:0] ex_in1;

  int n_checks;
  int n_errors;

  alu_stack_seq_if #(.W(16)) cmd_if ();

  alu_stack_seq #(
    .W    (16),
    .DEPTH(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd_if),
    .alu_op  (alu_op),
    .alu_in0 (alu_in0),
    .alu_in1 (alu_in1),
    .alu_out0(alu_out0),
    .alu_out1(alu_out1),
    .tos     (tos),
    .depth   (depth),
    .done    (done),
    .err     (err),
    .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: in0 is TOS, in1 is NOS.
  always_comb begin
    alu_out0 = '0;
    alu_out1 = '0;
    case (alu_op)
      5'd1:  alu_out0 = 16'd1;
      5'd2:  alu_out0 = alu_in0 + alu_in1;
      5'd3:  alu_out0 = alu_in0 - alu_in1;
      5'd6:  alu_out0 = alu_in0 & alu_in1;
      5'd7:  alu_out0 = alu_in0 | alu_in1;
      5'd8:  alu_out0 = ~alu_in0;
      5'd9:  alu_out0 = alu_in0 ^ alu_in1;
      5'd10: begin
        alu_out0 = alu_in1;
        alu_out1 = alu_in0;
      end
      5'd11: begin
        alu_out0 = alu_in0;
        alu_out1 = alu_in0;
      end
      5'd17: alu_out0 = alu_in0 + 16'd1;
      5'd18: alu_out0 = alu_in0 - 16'd1;
      default: begin
        alu_out0 = '0;
        alu_out1 = '0;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input int d, input int t, input int e);
    check({tag, " depth"}, 32'(depth), d);
    check({tag, " tos"}, 32'(tos), t);
    check({tag, " err"}, 32'(err), e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge where done is seen.
  task automatic issue(input string tag, input logic lit, input logic [4:0] op,
                       input logic [15:0] data, input int exp_lat, input logic hold,
                       input logic clr);
    int lat;
    int busy_ready;
    check({tag, " ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_lit   = lit;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    err_clr          = clr;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    if (!hold) begin
      // Scramble fields to show they were captured at the transfer.
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_lit   = ~lit;
      cmd_if.cmd_op    = 5'h1f;
      cmd_if.cmd_data  = 16'hdead;
    end
    lat        = 0;
    busy_ready = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        ex_op  = alu_op;
        ex_in0 = alu_in0;
        ex_in1 = alu_in1;
      end
      if (!done && cmd_if.cmd_ready) busy_ready++;
    end while (!done && lat < 12);
    cmd_if.cmd_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy ready"}, 32'(busy_ready), 32'd0);
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    err_clr          = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_lit   = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_data  = '0;
    ex_op            = '0;
    ex_in0           = '0;
    ex_in1           = '0;

    // Reset state, then 5 + 3.
    do_reset();
    check("rst ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst alu_in0", 32'(alu_in0), 32'd0);
    check("rst alu_in1", 32'(alu_in1), 32'd0);
    check_state("rst", 0, 0, 0);
    issue("lit5", 1'b1, 5'd0, 16'd5, 2, 1'b0, 1'b0);
    issue("lit3", 1'b1, 5'd0, 16'd3, 2, 1'b0, 1'b0);
    check_state("two lits", 2, 3, 0);
    issue("add", 1'b0, 5'd2, 16'd0, 4, 1'b0, 1'b0);
    check("add ex op", 32'(ex_op), 32'd2);
    check("add ex in0", 32'(ex_in0), 32'd3);
    check("add ex in1", 32'(ex_in1), 32'd5);
    check_state("add", 1, 8, 0);
    @(negedge clk);
    check("done one cycle", 32'(done), 32'd0);
    check("alu_op holds", 32'(alu_op), 32'd2);
    check("alu_in0 holds", 32'(alu_in0), 32'd3);

    // SUB wraps; SWP exchanges, revealed by a following ADD.
    do_reset();
    issue("s lit5", 1'b1, 5'd0, 16'd5, 2, 1'b0, 1'b0);
    issue("s lit3", 1'b1, 5'd0, 16'd3, 2, 1'b0, 1'b0);
    issue("sub", 1'b0, 5'd3, 16'd0, 4, 1'b0, 1'b0);
    check_state("sub", 1, 16'hfffe, 0);
    issue("lit7", 1'b1, 5'd0, 16'd7, 2, 1'b0, 1'b0);
    issue("lit9", 1'b1, 5'd0, 16'd9, 2, 1'b0, 1'b0);
    issue("swp", 1'b0, 5'd10, 16'd0, 4, 1'b0, 1'b0);
    check_state("swp", 3, 7, 0);
    issue("add2", 1'b0, 5'd2, 16'd0, 4, 1'b0, 1'b0);
    check("swp tos", 32'(ex_in0), 32'd7);
    check("swp nos", 32'(ex_in1), 32'd9);
    check_state("add2", 2, 16, 0);

    // Underflow on empty stack, then clear.
    do_reset();
    issue("not empty", 1'b0, 5'd8, 16'd0, 2, 1'b0, 1'b0);
    check_state("not empty", 0, 0, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err cleared", 32'(err), 32'd0);

    // Fill the stack, overflow, net-negative and net-zero ops at DEPTH.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue("fill", 1'b1, 5'd0, 16'(16'h10 + i), 2, 1'b0, 1'b0);
    end
    check_state("full", 8, 16'h17, 0);
    issue("lit ovf", 1'b1, 5'd0, 16'haaaa, 2, 1'b0, 1'b0);
    check_state("lit ovf", 8, 16'h17, 1);
    issue("add full", 1'b0, 5'd2, 16'd0, 4, 1'b0, 1'b0);
    check_state("add full", 7, 16'h2d, 1);
    issue("lit55", 1'b1, 5'd0, 16'h55, 2, 1'b0, 1'b0);
    check_state("lit55", 8, 16'h55, 1);
    issue("ovf clr", 1'b1, 5'd0, 16'hbbbb, 2, 1'b0, 1'b1);
    check_state("ovf clr", 8, 16'h55, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err cleared 2", 32'(err), 32'd0);
    issue("swp full", 1'b0, 5'd10, 16'd0, 4, 1'b0, 1'b0);
    check_state("swp full", 8, 16'h2d, 0);
    issue("dup full", 1'b0, 5'd11, 16'd0, 2, 1'b0, 1'b0);
    check_state("dup full", 8, 16'h2d, 1);

    // DUP with valid held, INC, undefined opcode 25.
    do_reset();
    issue("lit1", 1'b1, 5'd0, 16'd1, 2, 1'b0, 1'b0);
    issue("dup hold", 1'b0, 5'd11, 16'd0, 4, 1'b1, 1'b0);
    check_state("dup hold", 2, 1, 0);
    issue("inc", 1'b0, 5'd17, 16'd0, 4, 1'b0, 1'b0);
    check_state("inc", 2, 2, 0);
    issue("op25", 1'b0, 5'd25, 16'd0, 3, 1'b0, 1'b0);
    check_state("op25", 2, 2, 0);
    issue("sub nos", 1'b0, 5'd3, 16'd0, 4, 1'b0, 1'b0);
    check("inc nos", 32'(ex_in1), 32'd1);
    check_state("sub nos", 1, 1, 0);

    // Reset during EX aborts the ADD; reissue then underflows.
    do_reset();
    issue("lit4", 1'b1, 5'd0, 16'd4, 2, 1'b0, 1'b0);
    issue("lit6", 1'b1, 5'd0, 16'd6, 2, 1'b0, 1'b0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_lit   = 1'b0;
    cmd_if.cmd_op    = 5'd2;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort ex op", 32'(alu_op), 32'd2);
    check("abort ex in0", 32'(alu_in0), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_state("abort", 0, 0, 0);
    check("abort done", 32'(done), 32'd0);
    check("abort ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("abort alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    check("abort no late done", 32'(done), 32'd0);
    check("abort depth stays", 32'(depth), 32'd0);
    issue("add again", 1'b0, 5'd2, 16'd0, 2, 1'b0, 1'b0);
    check_state("add again", 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
